// File: rtl/expander.sv
// ----------------------------------------------------------------------------
// expander
// Companding expander: turns 9-bit companded samples (sign + 8-bit code) into
// 10-bit two's complement linear samples through a 2-stage valid/ready
// pipeline with full back-pressure.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all pipeline state
//   in_valid   in   1   din holds a sample
//   in_ready   out  1   block accepts din this cycle
//   din        in   9   din[8] sign, din[7:0] code
//   out_valid  out  1   dout holds an expanded sample
//   out_ready  in   1   sink takes dout this cycle
//   dout       out  10  signed linear sample
// ----------------------------------------------------------------------------
module expander (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] din,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] dout
);

    logic       r_s1_valid;
    logic       r_s1_sign;
    logic [7:0] r_s1_code;   // code already folded to the positive half
    logic       w_s2_load;
    logic       w_s1_load;
    logic [8:0] w_mag;

    // Piecewise-linear magnitude expansion, 8-bit code -> 9-bit magnitude.
    function automatic logic [8:0] expand_mag(input logic [7:0] c);
        logic [8:0] m1;
        logic [8:0] m2;
        logic [8:0] m4;
        m1 = {4'd0, c[4:0]};
        m2 = {3'd0, c[4:0], 1'b0};
        m4 = {2'd0, c[4:0], 2'b00};
        case (c[7:5])
            3'd0:    expand_mag = m1;
            3'd1:    expand_mag = 9'd32  + m1;
            3'd2:    expand_mag = 9'd64  + m1;
            3'd3:    expand_mag = 9'd96  + m2;
            3'd4:    expand_mag = 9'd160 + m2;
            3'd5:    expand_mag = 9'd224 + m4;
            3'd6:    expand_mag = 9'd352 + m4;
            default: expand_mag = 9'd480 + m1;
        endcase
    endfunction

    assign w_s2_load = r_s1_valid & (~out_valid | out_ready);
    // in_ready is combinational from out_ready so a full pipeline can still
    // accept on the same edge the sink drains it.
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_s1_load = in_valid & in_ready;
    assign w_mag     = expand_mag(r_s1_code);

    // Negative samples use ones'-complement symmetry: the code is inverted
    // on entry and the magnitude inverted again on exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_code  <= 8'd0;
        end else begin
            if (w_s1_load) begin
                r_s1_sign <= din[8];
                r_s1_code <= din[8] ? ~din[7:0] : din[7:0];
            end
            if (w_s1_load)
                r_s1_valid <= 1'b1;
            else if (w_s2_load)
                r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= 10'h000;
        end else begin
            if (w_s2_load) begin
                dout      <= {r_s1_sign, r_s1_sign ? ~w_mag : w_mag};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_expander.sv
module tb_expander;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] dout;

    always #5 clk = ~clk;

    expander dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    typedef struct {
        logic [9:0] exp_d;
        int         acc;
        logic [8:0] src;
    } ent_t;

    int         checks   = 0;
    int         errors   = 0;
    int         edge_cnt = 0;
    int         n_out    = 0;
    int         acc_cnt  = 0;
    bit         lat_chk  = 1'b0;
    logic [8:0] tbl [256];
    logic [9:0] got [512];
    ent_t       sb [$];

    task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, g, e);
        end
    endtask

    function automatic logic [9:0] model(input logic [8:0] d);
        logic [7:0] c;
        logic [8:0] mag;
        if (d[8]) begin
            c   = ~d[7:0];
            mag = ~tbl[c];
            return {1'b1, mag};
        end
        c = d[7:0];
        return {1'b0, tbl[c]};
    endfunction

    // One clock cycle: drive, observe at negedge, score, advance to posedge+1.
    task automatic cyc(input logic v, input logic [8:0] d, input logic [9:0] e, input logic ordy);
        ent_t ent;
        logic exp_ov;
        in_valid  = v;
        din       = d;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", in_ready, !(sb.size() == 2 && !ordy));
        exp_ov = (sb.size() > 0) && (sb[0].acc < edge_cnt);
        chk("out_valid", out_valid, exp_ov);
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                ent = sb.pop_front();
                chk("dout", dout, ent.exp_d);
                if (lat_chk) chk("latency", edge_cnt - ent.acc, 1);
                got[ent.src] = dout;
                n_out++;
            end
        end
        if (v && in_ready) begin
            ent.exp_d = e;
            ent.acc   = edge_cnt + 1;
            ent.src   = d;
            sb.push_back(ent);
            acc_cnt++;
        end
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) cyc(1'b0, 9'd0, 10'd0, 1'b1);
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int step [8] = '{1, 1, 1, 2, 2, 4, 4, 1};
        int n0;
        int start;
        int guard;
        logic [8:0] c9;
        logic [9:0] cmp;
        logic       v;
        logic       r;
        logic [8:0] d;

        // reference magnitude table built by accumulating per-segment steps
        tbl[0] = 9'd0;
        for (int c = 1; c < 256; c++) begin
            c9 = 9'(c - 1);
            tbl[c] = tbl[c-1] + 9'(step[c9[7:5]]);
        end

        // reset state; a sample offered during reset must not be taken
        reset     = 1'b1;
        in_valid  = 1'b1;
        din       = 9'h0FF;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 10'h000);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        cyc(1'b0, 9'd0, 10'd0, 1'b1);
        cyc(1'b0, 9'd0, 10'd0, 1'b1);

        // directed positive and negative decode, back-to-back
        lat_chk = 1'b1;
        cyc(1'b1, 9'h000, 10'h000, 1'b1);
        cyc(1'b1, 9'h07F, 10'h09E, 1'b1);
        cyc(1'b1, 9'h0A5, 10'h0F4, 1'b1);
        cyc(1'b1, 9'h0FF, 10'h1FF, 1'b1);
        cyc(1'b1, 9'h100, 10'h200, 1'b1);
        cyc(1'b1, 9'h1FF, 10'h3FF, 1'b1);
        cyc(1'b1, 9'h15A, 10'h30B, 1'b1);
        drain("drain_directed");

        // exhaustive sweep
        for (int i = 0; i < 512; i++) cyc(1'b1, 9'(i), model(9'(i)), 1'b1);
        drain("drain_sweep");
        for (int i = 0; i < 256; i++) begin
            cmp = ~got[9'(i) ^ 9'h1FF];
            chk("complement", got[i], cmp);
        end
        for (int i = 0; i < 255; i++) chk("monotonic", got[i+1] >= got[i], 1);

        // back-pressure
        lat_chk = 1'b0;
        cyc(1'b1, 9'h001, model(9'h001), 1'b0);
        cyc(1'b1, 9'h002, model(9'h002), 1'b0);
        in_valid  = 1'b1;
        din       = 9'h003;
        out_ready = 1'b0;
        #1;
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_dout", dout, 10'h001);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 9'h003, model(9'h003), 1'b0);
            chk("bp_hold_dout", dout, 10'h001);
            chk("bp_hold_valid", out_valid, 1);
        end
        n0 = n_out;
        cyc(1'b1, 9'h003, model(9'h003), 1'b1);
        chk("bp_rel1", n_out - n0, 1);
        cyc(1'b0, 9'd0, 10'd0, 1'b1);
        chk("bp_rel2", n_out - n0, 2);
        cyc(1'b0, 9'd0, 10'd0, 1'b1);
        chk("bp_rel3", n_out - n0, 3);
        drain("drain_bp");

        // random valid/ready bubbles
        start = acc_cnt;
        guard = 0;
        while (acc_cnt < start + 10000 && guard < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            d = 9'($urandom_range(0, 511));
            cyc(v, d, model(d), r);
            guard++;
        end
        chk("rand_accepted", acc_cnt - start, 10000);
        drain("drain_random");

        // reset with two samples in flight
        cyc(1'b1, 9'h07F, model(9'h07F), 1'b0);
        cyc(1'b1, 9'h0A5, model(9'h0A5), 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_dout", dout, 10'h000);
        sb.delete();
        @(posedge clk);
        edge_cnt++;
        #1;
        reset   = 1'b0;
        lat_chk = 1'b1;
        cyc(1'b1, 9'h0FF, 10'h1FF, 1'b1);
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
